// File: rtl/seq_mul_add_if.sv
// Operand/result bundle for the iterative multiply-add unit.
// Both sides use valid/ready: a transfer happens on the rising edge where valid and ready
// are both high; the sender must hold valid and data stable until that edge.
interface seq_mul_add_if #(
    parameter int BITWIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [BITWIDTH-1:0]     in_a;
    logic [BITWIDTH-1:0]     in_b;
    logic [BITWIDTH-1:0]     in_c;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*BITWIDTH-1:0]   out_result;

    modport master (
        output in_valid, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/seq_mul_add.sv
// Radix-2 shift-add multiply-add: result = a*b + c, one multiplier bit per cycle.
// Rebuilds a dividend from quotient, divisor and remainder beside the divider.
module seq_mul_add #(
    parameter int BITWIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_mul_add_if.slave     bus,
    output logic             busy,
    output logic [1:0]       dbg_state
);
    localparam int RW = 2 * BITWIDTH;
    localparam int CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(BITWIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [RW-1:0]       acc;
    logic [RW-1:0]       mcand;
    logic [RW-1:0]       acc_sum;
    logic [RW-1:0]       result_q;
    logic [BITWIDTH-1:0] mplier;
    logic [CW-1:0]       counter;
    logic                valid_q;

    // The last BUSY cycle must publish the accumulator including its own partial product.
    always_comb begin
        acc_sum = acc;
        if (mplier[0]) begin
            acc_sum = acc + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            counter  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc     <= {{BITWIDTH{1'b0}}, bus.in_c};
                        mcand   <= {{BITWIDTH{1'b0}}, bus.in_a};
                        mplier  <= bus.in_b;
                        counter <= '0;
                        busy    <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    acc     <= acc_sum;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + 1'b1;
                    // No early exit on a zero multiplier: latency is fixed at BITWIDTH cycles.
                    if (counter == LAST) begin
                        result_q <= acc_sum;
                        valid_q  <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = valid_q;
    assign bus.out_result = result_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_seq_mul_add.sv
// Bench for seq_mul_add: edge-counting reference model, per-cycle compare, literal scoreboard.
module tb_seq_mul_add;
    localparam int W  = 16;
    localparam int RW = 2 * W;

    logic clk;
    logic rst_n;
    logic busy;
    logic [1:0] dbg_state;

    seq_mul_add_if #(.BITWIDTH(W)) bus ();

    seq_mul_add #(.BITWIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [RW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase 0 waiting, 1 computing (counts down W edges), 2 holding result.
    int            m_ph = 0;
    int            m_left = 0;
    bit            m_vld = 1'b0;
    logic [RW-1:0] m_pending = '0;
    logic [RW-1:0] m_res = '0;
    int            cyc = 0;
    int            acc_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_ph  = 0;
            m_vld = 1'b0;
            m_res = '0;
        end else begin
            case (m_ph)
                0: if (bus.in_valid) begin
                    m_pending = RW'(bus.in_a) * RW'(bus.in_b) + RW'(bus.in_c);
                    m_left    = W;
                    acc_cyc   = cyc;
                    m_ph      = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ph  = 2;
                        m_vld = 1'b1;
                        m_res = m_pending;
                    end
                end
                default: if (bus.out_ready) begin
                    m_ph  = 0;
                    m_vld = 1'b0;
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    bit prev_vld = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(bus.in_ready), 64'(m_ph == 0));
            chk("busy", 64'(busy), 64'(m_ph == 1));
            chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
            if (m_vld) chk("out_result", 64'(bus.out_result), 64'(m_res));
            if (bus.out_valid && !prev_vld) begin
                chk("latency", 64'(cyc - acc_cyc), 64'(W));
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
                end else begin
                    chk("scoreboard", 64'(bus.out_result), 64'(exp_q.pop_front()));
                end
            end
            prev_vld = bus.out_valid;
        end else begin
            prev_vld = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [RW-1:0] exp, input bit push);
        bit ok;
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_c = c;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("result_timeout", 64'(ok), 64'd1);
    endtask

    task automatic drain(input int stall);
        wait_valid();
        repeat (stall) @(posedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] ra, rb, rc;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_c = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk_en = 1'b1;

        // Directed vectors with hand-computed results
        send(16'd3, 16'd5, 16'd2, 32'h0000_0011, 1'b1);             drain(0);
        send(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000, 1'b1);    drain(1);
        send(16'hFFFF, 16'hFFFF, 16'h0000, 32'hFFFE_0001, 1'b1);    drain(0);
        send(16'h1234, 16'h0000, 16'hABCD, 32'h0000_ABCD, 1'b1);    drain(2);
        send(16'h0000, 16'h8000, 16'h0000, 32'h0000_0000, 1'b1);    drain(0);

        // Backpressure: new operands offered while the result is held
        send(16'd7, 16'd9, 16'd1, 32'h0000_0040, 1'b1);
        wait_valid();
        @(posedge clk); #1;
        exp_q.push_back(32'h0000_0025);
        bus.in_valid = 1'b1;
        bus.in_a = 16'd5;
        bus.in_b = 16'd6;
        bus.in_c = 16'd7;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a = 16'hDEAD;
        drain(0);

        // Reset in the middle of a computation
        send(16'd100, 16'd200, 16'd0, '0, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_result", 64'(bus.out_result), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        send(16'd2, 16'd3, 16'd4, 32'h0000_000A, 1'b1);             drain(0);

        // Random regression with random consumer stalls
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom_range(0, 65535));
            rb = W'($urandom_range(0, 65535));
            rc = W'($urandom_range(0, 65535));
            send(ra, rb, rc, RW'(ra) * RW'(rb) + RW'(rc), 1'b1);
            drain(int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
